// File: rtl/sixteen_bit_or_serializer.sv
// Bit-serial transmitter for the bitwise OR of two operands, sent LSB first with valid/ready per bit.
// Optional trailing even-parity bit when SIXTEEN_BIT_OR_PARITY_EN is defined.
//
// state    | meaning
// IDLE     | waiting for operands, in_ready high
// SHIFT    | sending data bits from shift_reg[0]
// PARITY   | sending the latched parity bit (SIXTEEN_BIT_OR_PARITY_EN only)
module sixteen_bit_or_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SIXTEEN_BIT_OR_PARITY_EN
  localparam logic [1:0] S_PARITY     = 2'd2;
  localparam logic       LAST_ON_DATA = 1'b0;
`else
  localparam logic       LAST_ON_DATA = 1'b1;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             at_end;

  // in_ready is gated by rst_n so it reads low while reset is held
  assign in_ready = rst_n & (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign at_end   = (cnt == CNT_W'(WIDTH - 1));

`ifdef SIXTEEN_BIT_OR_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^(a | b);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift_reg <= a | b;
            cnt       <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            cnt       <= cnt + CNT_W'(1);
            if (at_end) begin
`ifdef SIXTEEN_BIT_OR_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_IDLE;
`endif
            end
          end
        end
`ifdef SIXTEEN_BIT_OR_PARITY_EN
        S_PARITY: begin
          if (ser_ready) begin
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = shift_reg[0];
        ser_last  = LAST_ON_DATA & at_end;
      end
`ifdef SIXTEEN_BIT_OR_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = parity;
        ser_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sixteen_bit_or_serializer.sv
// Self-checking bench: queue-of-expected-bits model, per-cycle compare, directed and random traffic.
module tb_sixteen_bit_or_serializer;
  localparam int WIDTH = 16;
`ifdef SIXTEEN_BIT_OR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = WIDTH + PAR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic ser_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic in_ready, ser_valid, ser_out, ser_last, busy;

  int checks = 0;
  int passes = 0;

  bit exp_q[$];
  logic [FL-1:0] frames[$];
  int frame_len[$];
  int first_cyc[$];
  int last_cyc[$];
  logic [FL-1:0] rx_data = '0;
  int rx_n = 0;
  int xfers = 0;
  int busy_cycles = 0;
  int acc_cnt = 0;
  int cyc = 0;

  sixteen_bit_or_serializer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ser_ready(ser_ready), .ser_valid(ser_valid),
    .ser_out(ser_out), .ser_last(ser_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected frame: WIDTH bits of the OR, LSB first, then even parity if enabled
  function automatic void push_frame(logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
    if (PAR == 1) exp_q.push_back(bit'($countones(w) % 2));
  endfunction

  // Model and receiver: sampled at the rising edge, before the DUT state updates
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      rx_n = 0;
      rx_data = '0;
    end else begin
      cyc++;
      if (busy) busy_cycles++;
      if (ser_valid && ser_ready) begin
        if (rx_n == 0) first_cyc.push_back(cyc);
        if (rx_n < FL) rx_data[rx_n] = ser_out;
        rx_n++;
        xfers++;
        if (ser_last) begin
          frames.push_back(rx_data);
          frame_len.push_back(rx_n);
          last_cyc.push_back(cyc);
          rx_n = 0;
          rx_data = '0;
        end
      end
      if (exp_q.size() == 0) begin
        if (in_valid) begin
          push_frame(a | b);
          acc_cnt++;
        end
      end else if (ser_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_ser_valid", ser_valid, 0);
      check("rst_ser_out", ser_out, 0);
      check("rst_ser_last", ser_last, 0);
      check("rst_busy", busy, 0);
    end else begin
      check("in_ready", in_ready, exp_q.size() == 0);
      check("ser_valid", ser_valid, exp_q.size() != 0);
      check("busy", busy, exp_q.size() != 0);
      check("ser_last", ser_last, exp_q.size() == 1);
      if (exp_q.size() != 0) check("ser_out", ser_out, exp_q[0]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
    int start = acc_cnt;
    int k = 0;
    a = x;
    b = y;
    in_valid = 1'b1;
    while (acc_cnt == start && k < 200) begin
      tick();
      k++;
    end
    check("accept_timeout", acc_cnt != start, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(int n);
    int k = 0;
    while (frames.size() < n && k < 300) begin
      tick();
      k++;
    end
    check("frame_timeout", frames.size() >= n, 1);
  endtask

  task automatic wait_xfers(int n);
    int k = 0;
    while (xfers < n && k < 300) begin
      tick();
      k++;
    end
    check("xfer_timeout", xfers >= n, 1);
  endtask

  initial begin
    int base, x0, fc, lc, acc0;
    repeat (3) tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", in_ready, 1);

    // Basic frame
    ser_ready = 1'b1;
    base = frames.size();
    send(16'h00F0, 16'h0F01);
    wait_frames(base + 1);
    check("basic_in_ready_after", in_ready, 1);
    if (frames.size() > base) begin
      check("basic_data", frames[base][WIDTH-1:0], 16'h0FF1);
      check("basic_len", frame_len[base], FL);
`ifdef SIXTEEN_BIT_OR_PARITY_EN
      check("basic_parity", frames[base][WIDTH], 1);
`endif
    end

    // Backpressure
    base = frames.size();
    send(16'hFFFF, 16'h0000);
    busy_cycles = 0;
    x0 = xfers;
    wait_xfers(x0 + 5);
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ser_out", ser_out, 1);
      check("stall_xfers", xfers - x0, 5);
    end
    ser_ready = 1'b1;
    wait_frames(base + 1);
    check("bp_transfers", xfers - x0, FL);
    check("bp_busy_cycles", busy_cycles, 19 + PAR);
    if (frames.size() > base) check("bp_data", frames[base][WIDTH-1:0], 16'hFFFF);

    // Ignored input while shifting
    base = frames.size();
    acc0 = acc_cnt;
    send(16'h0F0F, 16'h0000);
    repeat (3) tick();
    a = 16'hAAAA;
    in_valid = 1'b1;
    check("ign_in_ready", in_ready, 0);
    repeat (2) tick();
    in_valid = 1'b0;
    a = '0;
    wait_frames(base + 1);
    repeat (20) tick();
    check("ign_frame_count", frames.size() - base, 1);
    check("ign_accepts", acc_cnt - acc0, 1);
    if (frames.size() > base) check("ign_data", frames[base][WIDTH-1:0], 16'h0F0F);

    // Reset mid-frame, away from any clock edge
    base = frames.size();
    x0 = xfers;
    send(16'hFFFF, 16'h0000);
    wait_xfers(x0 + 8);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ser_valid", ser_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ser_last", ser_last, 0);
    check("midrst_no_frame", frames.size() - base, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(16'h0001, 16'h0000);
    wait_frames(base + 1);
    if (frames.size() > base) check("post_rst_data", frames[base][WIDTH-1:0], 16'h0001);

    // Back-to-back
    base = frames.size();
    fc = first_cyc.size();
    lc = last_cyc.size();
    send(16'h8000, 16'h0000);
    send(16'h0000, 16'h0001);
    wait_frames(base + 2);
    if (frames.size() > base + 1 && first_cyc.size() > fc + 1) begin
      check("b2b_first", frames[base][WIDTH-1:0], 16'h8000);
      check("b2b_last_bit", frames[base][FL-1], 1);
      check("b2b_second", frames[base+1][WIDTH-1:0], 16'h0001);
      check("b2b_second_bit0", frames[base+1][0], 1);
      check("b2b_gap", first_cyc[fc+1] - last_cyc[lc], 2);
    end

`ifdef SIXTEEN_BIT_OR_PARITY_EN
    base = frames.size();
    send(16'h0007, 16'h0008);
    wait_frames(base + 1);
    send(16'h0007, 16'h0000);
    wait_frames(base + 2);
    if (frames.size() > base + 1) begin
      check("par_data", frames[base][WIDTH-1:0], 16'h000F);
      check("par_bit_even", frames[base][WIDTH], 0);
      check("par_len", frame_len[base], 17);
      check("par_bit_odd", frames[base+1][WIDTH], 1);
    end
`endif

    // Random traffic
    base = frames.size();
    acc0 = acc_cnt;
    x0 = acc_cnt;
    for (int i = 0; i < 1500; i++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && acc_cnt != x0) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 5) == 0) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        in_valid = 1'b1;
        x0 = acc_cnt;
      end
      tick();
    end
    ser_ready = 1'b1;
    for (int k = 0; k < 40 && in_valid && acc_cnt == x0; k++) tick();
    in_valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_frames", frames.size() - base, acc_cnt - acc0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_or_serializer.md
Name: sixteen_bit_or_serializer

Overview:
- Accepts two parallel 16-bit operands through a valid/ready handshake and forms their bitwise OR.
- Transmits the OR result as a bit-serial stream, LSB first, with per-bit valid/ready flow control and a last-bit marker.
- Serves as the transmit end of the parallel OR datapath, so that a word can be carried over a single-wire link to a downstream deserializer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥2.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W ≥ WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ser_ready  input  1  downstream accepts ser_out this cycle.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_out  output  1  current serial bit.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; shift register=0; counter=0.
- Output values during reset: in_ready=0, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- First edge after rst_n deasserts: state is IDLE and in_ready=1.
- States: IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- IDLE:
  - in_ready=1, ser_valid=0, busy=0.
  - Accept occurs on a rising edge where in_valid=1 and in_ready=1.
  - On accept: shift register ← a | b (bitwise, WIDTH bits, no carry); counter ← 0; next state SHIFT.
- SHIFT:
  - in_ready=0, busy=1, ser_valid=1, ser_out=shift_reg[0].
  - ser_last=1 only when counter==WIDTH-1 and PARITY is not compiled in.
  - Bit transfer occurs on an edge where ser_valid=1 and ser_ready=1.
  - On transfer: shift register shifts right by 1, zero-filled; counter increments.
  - On transfer with counter==WIDTH-1: go to IDLE, or to PARITY if compiled in.
  - While ser_ready=0: ser_out, ser_last and the counter are held stable; no bit is lost or repeated.
- Latency: operands accepted at edge N; bit 0 is valid in the cycle after edge N.
- Throughput: with ser_ready tied high, one frame per WIDTH+1 cycles (WIDTH shift cycles plus one IDLE accept cycle); there is no back-to-back overlap.
- in_valid while busy: ignored; operands are not captured. The upstream must hold in_valid until in_ready is sampled high.
- a and b change while in SHIFT: no effect; the captured value is used.
- Reset mid-frame: the frame is dropped immediately and all outputs return to reset values; the receiver sees ser_valid fall without ser_last.
- The counter never wraps inside a frame; it is cleared on every accept.

Optional Feature:
- Macro: SIXTEEN_BIT_OR_PARITY_EN.
- Defined:
  - Captured parity is the XOR-reduction of a|b, latched at accept.
  - After data bit WIDTH-1 is transferred, state=PARITY.
  - In PARITY: ser_valid=1, ser_out=captured parity (even parity: the total count of ones in data+parity is even), ser_last=1.
  - On ser_ready=1 in PARITY: go to IDLE.
  - Frame length is WIDTH+1 bits; ser_last is never asserted on a data bit.
- Undefined: the PARITY state and parity register are absent; the frame is WIDTH bits with ser_last on bit WIDTH-1.

Test Plan:
- Basic frame: a=16'h00F0, b=16'h0F01, ser_ready=1 throughout.
  - Expect ser_out LSB first = 1,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0 (value 16'h0FF1).
  - Expect ser_last only on the 16th bit, and in_ready=1 again on the following cycle.
- Backpressure: a=16'hFFFF, b=0; drop ser_ready for 3 cycles after bit 5.
  - Expect ser_out held at 1 and the counter frozen during the stall.
  - Expect exactly 16 transfers in total, with busy high for 19 cycles.
- Ignored input: during SHIFT, pulse in_valid with a=16'hAAAA.
  - Expect the current frame unchanged and no second frame started.
  - Expect in_ready=0 throughout SHIFT.
- Reset mid-frame: assert rst_n=0 asynchronously after bit 7 (not at a clock edge).
  - Expect ser_valid, busy and ser_last to fall immediately.
  - Expect the next accepted word a=16'h0001, b=0 to transmit cleanly as 1 followed by 15 zeros.
- Back-to-back: hold in_valid=1 with two words, 16'h8000|0 then 16'h0000|16'h0001.
  - Expect the first frame to end with ser_last on a 1, and 1 IDLE cycle between frames.
  - Expect the second frame to start with bit 1.
- SIXTEEN_BIT_OR_PARITY_EN defined: a=16'h0007, b=16'h0008.
  - Expect data 16'h000F (4 ones) followed by parity bit 0, with ser_last on the 17th bit.
  - With a=16'h0007, b=0: expect parity bit 1.
